regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined CPU datapath; successor to the fixed 32x32 2-read file.

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_sweep_ctrl.sv | 66 ++++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file:
//   - default geometry (DW_DEF / AW_DEF / NR_DEF)
//   - soft-clear FSM state encoding (ST_IDLE, ST_SWEEP)
//   - merge_be(): byte-enable merge of a new word over an old word.
//     The function works on a fixed maximum width. Callers zero-extend
//     their operands into it and truncate the result back to DW.
package regfile_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;
   localparam int NR_DEF = 2;

   // Widest data word merge_be() can handle.
   localparam int MAX_DW = 256;
   localparam int MAX_BE = MAX_DW / 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

   // Byte k of the result comes from new_val when be[k] is set, else from old_val.
   function automatic logic [MAX_DW-1:0] merge_be(input logic [MAX_DW-1:0] old_val,
                                                  input logic [MAX_DW-1:0] new_val,
                                                  input logic [MAX_BE-1:0] be);
      logic [MAX_DW-1:0] res;
      res = old_val;
      for (int k = 0; k < MAX_BE; k++) begin
         if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// regfile_sweep_ctrl
//   Soft-clear sequencer. A clr_req seen in IDLE starts a sweep that visits
//   every register address once, one per cycle, then returns to IDLE.
// Ports
//   Clk        in   clock
//   Clrn       in   asynchronous active-low reset
//   clr_req    in   start a sweep (ignored while a sweep is running)
//   ready      out  1 when idle; registered, drops at the edge that starts the sweep
//   sweep_en   out  1 while sweeping; the register file clears sweep_addr this cycle
//   sweep_addr out  address being cleared this cycle
module regfile_sweep_ctrl
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          Clk,
   input  logic          Clrn,
   input  logic          clr_req,
   output logic          ready,
   output logic          sweep_en,
   output logic [AW-1:0] sweep_addr
);

   // DEPTH-1 is all ones, so the counter never needs to wrap.
   localparam logic [AW-1:0] LAST_ADDR = '1;

   sweep_state_t  state_reg;
   logic [AW-1:0] cnt_reg;
   logic          ready_reg;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (clr_req) begin
                  state_reg <= ST_SWEEP;
                  cnt_reg   <= '0;
                  ready_reg <= 1'b0;
               end
            end
            ST_SWEEP: begin
               if (cnt_reg == LAST_ADDR) begin
                  state_reg <= ST_IDLE;
                  cnt_reg   <= '0;
                  ready_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + AW'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign ready      = ready_reg;
   assign sweep_en   = (state_reg == ST_SWEEP);
   assign sweep_addr = cnt_reg;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-read-port register file with byte-enable writes, same-cycle
//   write->read bypass, per-register busy scoreboard, soft-clear sweep and
//   a raw debug read port.
// Ports
//   Clk       in   clock
//   Clrn      in   asynchronous active-low reset
//   rd_addr   in   NR*AW  read addresses, port i at [i*AW +: AW]
//   rd_data   out  NR*DW  read data, port i at [i*DW +: DW] (combinational)
//   rd_busy   out  NR     busy flag of the register addressed by port i
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_be     in   DW/8 byte enables
//   wr_data   in   write data
//   sb_set    in   mark sb_addr busy
//   sb_addr   in   scoreboard set address
//   clr_req   in   start soft-clear sweep
//   ready     out  1 = idle, writes and sb_set accepted
//   dbg_addr  in   debug read address
//   dbg_data  out  raw contents of dbg_addr (no bypass, no zero masking)
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NR       = NR_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR*DW-1:0] rd_data,
   output logic [NR-1:0]    rd_busy,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [DW/8-1:0]  wr_be,
   input  logic [DW-1:0]    wr_data,
   input  logic             sb_set,
   input  logic [AW-1:0]    sb_addr,
   input  logic             clr_req,
   output logic             ready,
   input  logic [AW-1:0]    dbg_addr,
   output logic [DW-1:0]    dbg_data
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    mem_reg [DEPTH];
   logic [DEPTH-1:0] busy_reg;

   logic          sweep_en;
   logic [AW-1:0] sweep_addr;

   regfile_sweep_ctrl #(.AW(AW)) u_sweep (
      .Clk        (Clk),
      .Clrn       (Clrn),
      .clr_req    (clr_req),
      .ready      (ready),
      .sweep_en   (sweep_en),
      .sweep_addr (sweep_addr)
   );

   logic          wr_fire;
   logic          sb_fire;
   logic          byp_live;
   logic [DW-1:0] wr_merged;

   assign wr_fire  = wr_en && ready && !(ZERO_REG && (wr_addr == '0));
   assign sb_fire  = sb_set && ready && !(ZERO_REG && (sb_addr == '0));
   assign byp_live = BYPASS && wr_en && ready;

   // The merged word serves both the stored update and the bypass path:
   // a bypass hit always targets wr_addr, so one merge covers every port.
   assign wr_merged = DW'(merge_be(MAX_DW'(mem_reg[wr_addr]), MAX_DW'(wr_data), MAX_BE'(wr_be)));

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
         busy_reg <= '0;
      end else if (sweep_en) begin
         mem_reg[sweep_addr]  <= '0;
         busy_reg[sweep_addr] <= 1'b0;
      end else begin
         // A write with wr_be=0 still retires the producer (clears busy).
         if (wr_fire) begin
            mem_reg[wr_addr]  <= wr_merged;
            busy_reg[wr_addr] <= 1'b0;
         end
         // Placed after the clear so a new producer wins on the same address.
         if (sb_fire) busy_reg[sb_addr] <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_rd
         logic [AW-1:0] ra;
         logic          masked;
         logic          hit;

         assign ra     = rd_addr[gi*AW +: AW];
         assign masked = ZERO_REG && (ra == '0);
         assign hit    = byp_live && (wr_addr == ra) && !masked;

         assign rd_data[gi*DW +: DW] = masked ? '0 : (hit ? wr_merged : mem_reg[ra]);
         // A register being written this cycle is reported free already.
         assign rd_busy[gi] = !masked && busy_reg[ra] && !hit;
      end
   endgenerate

   assign dbg_data = mem_reg[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic Clk = 1'b0;
   logic Clrn = 1'b0;
   always #5 Clk = ~Clk;

   // Default-geometry instance (32x32, 2 read ports, zero register)
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [3:0]  wr_be = '0;
   logic [31:0] wr_data = '0;
   logic        sb_set = 1'b0;
   logic [4:0]  sb_addr = '0;
   logic        clr_req = 1'b0;
   logic        ready;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   // 64-bit, 16-entry, 3-port instance with a writable r0
   logic [11:0]  b_rd_addr = '0;
   logic [191:0] b_rd_data;
   logic [2:0]   b_rd_busy;
   logic         b_wr_en = 1'b0;
   logic [3:0]   b_wr_addr = '0;
   logic [7:0]   b_wr_be = '0;
   logic [63:0]  b_wr_data = '0;
   logic         b_sb_set = 1'b0;
   logic [3:0]   b_sb_addr = '0;
   logic         b_clr_req = 1'b0;
   logic         b_ready;
   logic [3:0]   b_dbg_addr = '0;
   logic [63:0]  b_dbg_data;

   regfile_mp dut (
      .Clk(Clk), .Clrn(Clrn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req), .ready(ready),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   regfile_mp #(.DW(64), .AW(4), .NR(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut64 (
      .Clk(Clk), .Clrn(Clrn), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
      .sb_set(b_sb_set), .sb_addr(b_sb_addr), .clr_req(b_clr_req), .ready(b_ready),
      .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
   );

   typedef struct packed {
      logic        we;
      logic [4:0]  wa;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        sb;
      logic [4:0]  sa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  da;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] ed;
      logic [1:0]  eb;
   } vec_t;

   typedef struct packed {
      logic [15:0] id;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] ed;
      logic [1:0]  eb;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[18];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [3:0] be,
                               input logic [31:0] wd, input logic sb, input logic [4:0] sa,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] da,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] ed,
                               input logic [1:0] eb);
      vec_t v;
      v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.sb = sb; v.sa = sa;
      v.ra0 = ra0; v.ra1 = ra1; v.da = da; v.e0 = e0; v.e1 = e1; v.ed = ed; v.eb = eb;
      return v;
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   // One cycle of stimulus on the default instance; expectation queued at drive
   // time, popped and compared at the following falling edge.
   task automatic run_vec(input vec_t v, input int id);
      exp_t e;
      @(posedge Clk); #1;
      wr_en = v.we; wr_addr = v.wa; wr_be = v.be; wr_data = v.wd;
      sb_set = v.sb; sb_addr = v.sa; rd_addr = {v.ra1, v.ra0}; dbg_addr = v.da;
      e.id = 16'(id); e.e0 = v.e0; e.e1 = v.e1; e.ed = v.ed; e.eb = v.eb;
      exp_q.push_back(e);
      @(negedge Clk);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 64'(0), 64'(1));
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("v%0d_rd0", e.id), 64'(rd_data[31:0]), 64'(e.e0));
         chk($sformatf("v%0d_rd1", e.id), 64'(rd_data[63:32]), 64'(e.e1));
         chk($sformatf("v%0d_dbg", e.id), 64'(dbg_data), 64'(e.ed));
         chk($sformatf("v%0d_busy", e.id), 64'(rd_busy), 64'(e.eb));
         $display("txn %0d rd0=%h rd1=%h dbg=%h busy=%b", e.id, rd_data[31:0], rd_data[63:32], dbg_data, rd_busy);
      end
   endtask

   task automatic drive_wr(input logic [4:0] a, input logic [31:0] d);
      @(posedge Clk); #1;
      wr_en = 1'b1; wr_addr = a; wr_be = 4'hF; wr_data = d; sb_set = 1'b0;
   endtask

   task automatic go_idle();
      @(posedge Clk); #1;
      wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
   endtask

   // Pulse clr_req and count cycles with ready low (bounded).
   // With inject set, a write / sb_set / clr_req is attempted mid-sweep.
   task automatic sweep(input bit inject, output int low);
      @(posedge Clk); #1;
      wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b1;
      @(posedge Clk); #1;
      clr_req = 1'b0;
      low = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         if (ready) break;
         low++;
         if (inject && low == 10) begin
            chk("mid_sweep_r31_kept", 64'(rd_data[31:0]), 64'h1000001F);
            chk("mid_sweep_r2_cleared", 64'(rd_data[63:32]), 64'h0);
            wr_en = 1'b1; wr_addr = 5'd2; wr_be = 4'hF; wr_data = 32'hABCD1234;
            sb_set = 1'b1; sb_addr = 5'd2; clr_req = 1'b1;
            #1;
            chk("mid_sweep_no_bypass", 64'(rd_data[63:32]), 64'h0);
            chk("mid_sweep_no_busy", 64'(rd_busy), 64'h0);
         end
         if (inject && low == 11) begin
            wr_en = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
         end
      end
      $display("sweep ready_low_cycles=%0d", low);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int low;

      vecs[0]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 5'd5, 32'h0,        32'h0,        32'h0,        2'b00);
      vecs[1]  = mk(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00);
      vecs[2]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
      vecs[3]  = mk(1'b1, 5'd0, 4'hF, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00);
      vecs[4]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00);
      vecs[5]  = mk(1'b1, 5'd7, 4'hF, 32'h11223344, 1'b0, 5'd0, 5'd7, 5'd5, 5'd7, 32'h11223344, 32'hDEADBEEF, 32'h0,        2'b00);
      vecs[6]  = mk(1'b1, 5'd7, 4'h5, 32'hAABBCCDD, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 2'b00);
      vecs[7]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 5'd7, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 2'b00);
      vecs[8]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        32'h0,        2'b00);
      vecs[9]  = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 5'd9, 32'h0,        32'hDEADBEEF, 32'h0,        2'b01);
      vecs[10] = mk(1'b1, 5'd9, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        2'b00);
      vecs[11] = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00);
      vecs[12] = mk(1'b1, 5'd9, 4'h3, 32'h55555555, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9, 32'hCAFE5555, 32'hCAFE5555, 32'hCAFEF00D, 2'b00);
      vecs[13] = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFE5555, 32'hCAFE5555, 32'hCAFE5555, 2'b11);
      vecs[14] = mk(1'b1, 5'd9, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFE5555, 32'hCAFE5555, 32'hCAFE5555, 2'b00);
      vecs[15] = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 32'hCAFE5555, 32'hCAFE5555, 32'hCAFE5555, 2'b00);
      vecs[16] = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 5'd0, 32'h0,        32'hCAFE5555, 32'h0,        2'b00);
      vecs[17] = mk(1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 32'h0,        32'hCAFE5555, 32'h0,        2'b00);

      // Reset
      Clrn = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Clrn = 1'b1;
      chk("reset_ready", 64'(ready), 64'h1);
      chk("reset_ready64", 64'(b_ready), 64'h1);

      // Read / write / bypass / scoreboard table
      for (int i = 0; i < 18; i++) run_vec(vecs[i], i);
      go_idle();

      // Sweep: fill r1..r31, mark r3 busy, then clear everything
      for (int i = 1; i < 32; i++) drive_wr(5'(i), 32'h10000000 | 32'(i));
      run_vec(mk(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd31, 5'd3, 32'h10000003, 32'h1000001F, 32'h10000003, 2'b00), 50);
      run_vec(mk(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd31, 5'd3, 32'h10000003, 32'h1000001F, 32'h10000003, 2'b01), 51);
      @(negedge Clk);
      sb_set = 1'b0;
      rd_addr = {5'd2, 5'd31};
      sweep(1'b1, low);
      chk("sweep_ready_low_cycles", 64'(low), 64'd32);
      chk("sweep_ready_after", 64'(ready), 64'h1);
      for (int a = 0; a < 32; a++)
         run_vec(mk(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a), 5'(a), 32'h0, 32'h0, 32'h0, 2'b00), 100 + a);

      // Reset in the middle of a sweep
      drive_wr(5'd30, 32'h30303030);
      drive_wr(5'd2, 32'h22222222);
      go_idle();
      @(negedge Clk);
      rd_addr = {5'd2, 5'd30};
      dbg_addr = 5'd30;
      @(posedge Clk); #1;
      clr_req = 1'b1;
      @(posedge Clk); #1;
      clr_req = 1'b0;
      for (int c = 0; c < 9; c++) @(negedge Clk);
      @(negedge Clk);
      chk("midrst_ready_low_before", 64'(ready), 64'h0);
      chk("midrst_r30_before", 64'(dbg_data), 64'h30303030);
      Clrn = 1'b0;
      #1;
      chk("midrst_ready", 64'(ready), 64'h1);
      chk("midrst_dbg_r30", 64'(dbg_data), 64'h0);
      chk("midrst_rd_r30", 64'(rd_data[31:0]), 64'h0);
      dbg_addr = 5'd2;
      #1;
      chk("midrst_dbg_r2", 64'(dbg_data), 64'h0);
      @(negedge Clk);
      Clrn = 1'b1;
      sweep(1'b0, low);
      chk("restart_sweep_cycles", 64'(low), 64'd32);
      run_vec(mk(1'b1, 5'd4, 4'hF, 32'h44440000, 1'b0, 5'd0, 5'd4, 5'd30, 5'd30, 32'h44440000, 32'h0, 32'h0, 2'b00), 200);
      go_idle();

      // Wide / 3-port / writable r0 instance
      @(posedge Clk); #1;
      b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_be = 8'hFF; b_wr_data = 64'h0123456789ABCDEF;
      b_rd_addr = {4'd0, 4'd0, 4'd0}; b_dbg_addr = 4'd0;
      @(negedge Clk);
      for (int p = 0; p < 3; p++) chk($sformatf("w64_byp_p%0d", p), b_rd_data[p*64 +: 64], 64'h0123456789ABCDEF);
      chk("w64_dbg_nobyp", b_dbg_data, 64'h0);
      $display("txn w64_0 rd0=%h", b_rd_data[63:0]);
      @(posedge Clk); #1;
      b_wr_addr = 4'd15; b_wr_data = 64'hFEDCBA9876543210; b_sb_set = 1'b1; b_sb_addr = 4'd0;
      b_rd_addr = {4'd0, 4'd0, 4'd15};
      @(negedge Clk);
      chk("w64_byp_r15", b_rd_data[63:0], 64'hFEDCBA9876543210);
      chk("w64_r0_stored", b_rd_data[127:64], 64'h0123456789ABCDEF);
      chk("w64_busy_not_yet", 64'(b_rd_busy), 64'h0);
      $display("txn w64_1 rd0=%h rd1=%h", b_rd_data[63:0], b_rd_data[127:64]);
      @(posedge Clk); #1;
      b_wr_en = 1'b0; b_sb_set = 1'b0;
      b_rd_addr = {4'd0, 4'd15, 4'd0}; b_dbg_addr = 4'd15;
      @(negedge Clk);
      chk("w64_r0_read", b_rd_data[63:0], 64'h0123456789ABCDEF);
      chk("w64_busy", 64'(b_rd_busy), 64'b101);
      chk("w64_dbg_r15", b_dbg_data, 64'hFEDCBA9876543210);
      $display("txn w64_2 busy=%b", b_rd_busy);
      @(posedge Clk); #1;
      b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_be = 8'h0F; b_wr_data = 64'hFFFFFFFF00000000;
      b_dbg_addr = 4'd0;
      @(negedge Clk);
      chk("w64_partial_byp", b_rd_data[63:0], 64'h0123456700000000);
      chk("w64_busy_byp", 64'(b_rd_busy), 64'h0);
      $display("txn w64_3 rd0=%h", b_rd_data[63:0]);
      @(posedge Clk); #1;
      b_wr_en = 1'b0;
      @(negedge Clk);
      chk("w64_partial_stored", b_dbg_data, 64'h0123456700000000);
      chk("w64_busy_cleared", 64'(b_rd_busy), 64'h0);
      $display("txn w64_4 dbg=%h", b_dbg_data);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
